// File: rtl/dpu_csr_bank.sv
// dpu_csr_bank: APB register bank for a multi-channel engine. It provides start, busy and done handshakes and per-channel ADDR/LEN registers.
// Define DPU_CSR_IRQ_EN to build the interrupt logic (IRQ_EN, IRQ_STAT, irq_o). Without it, irq_o is tied to 0.

module dpu_csr_bank #(
  parameter int APB_WIDTH_AD = 32,
  parameter int APB_WIDTH_DA = 32,
  parameter int AXI_WIDTH_AD = 32,
  parameter int AXI_WIDTH_DA = 32,
  parameter int NUM_CH       = 4
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic [APB_WIDTH_AD-1:0] PADDR,
  input  logic                    PWRITE,
  input  logic [APB_WIDTH_DA-1:0] PWDATA,
  output logic [APB_WIDTH_DA-1:0] PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic [NUM_CH-1:0]       go_o,
  output logic [NUM_CH*32-1:0]    addr_o,
  output logic [NUM_CH*32-1:0]    len_o,
  input  logic [NUM_CH-1:0]       done_i,
  output logic                    irq_o
);

  localparam logic [31:0] VERSION = 32'h2021_1106;
  localparam logic [31:0] CONFIG  = {8'(NUM_CH), 8'h00, 8'(AXI_WIDTH_AD), 8'(AXI_WIDTH_DA)};

  logic [7:0]              regAddr;
  logic                    unusedAddrHi;
  logic [NUM_CH-1:0][31:0] addr_q;
  logic [NUM_CH-1:0][31:0] len_q;
  logic [NUM_CH-1:0]       busy_q, busy_d;
  logic [NUM_CH-1:0]       go_q, go_d;
  logic [NUM_CH-1:0]       doneHit;
  logic [NUM_CH-1:0]       ctrlSel, addrSel, lenSel;
  logic [31:0]             prdata_q, rdata;
  logic                    mapped, blockErr, accessPh, wrEn, rdSetup;
`ifdef DPU_CSR_IRQ_EN
  logic                    ienSel, istSel;
  logic [NUM_CH-1:0]       irqEn_q, irqStat_q, irqStat_d;
  logic                    irq_q;
`endif

  assign regAddr      = PADDR[7:0];
  assign unusedAddrHi = ^PADDR[APB_WIDTH_AD-1:8];

  // Address decode and read mux. Only exact, word-aligned hits on an existing channel count as mapped.
  always_comb begin
    mapped  = 1'b0;
    rdata   = '0;
    ctrlSel = '0;
    addrSel = '0;
    lenSel  = '0;
`ifdef DPU_CSR_IRQ_EN
    ienSel  = 1'b0;
    istSel  = 1'b0;
`endif
    case (regAddr)
      8'h00: begin
        mapped = 1'b1;
        rdata  = VERSION;
      end
      8'h04: begin
        mapped = 1'b1;
        rdata  = CONFIG;
      end
`ifdef DPU_CSR_IRQ_EN
      8'h08: begin
        mapped = 1'b1;
        ienSel = 1'b1;
        rdata  = 32'(irqEn_q);
      end
      8'h0C: begin
        mapped = 1'b1;
        istSel = 1'b1;
        rdata  = 32'(irqStat_q);
      end
`endif
      default: ;
    endcase
    for (int c = 0; c < NUM_CH; c++) begin
      if (regAddr == 8'(64 + 16 * c)) begin
        mapped     = 1'b1;
        ctrlSel[c] = 1'b1;
        rdata      = {30'd0, busy_q[c], 1'b0};
      end
      if (regAddr == 8'(68 + 16 * c)) begin
        mapped     = 1'b1;
        addrSel[c] = 1'b1;
        rdata      = addr_q[c];
      end
      if (regAddr == 8'(72 + 16 * c)) begin
        mapped    = 1'b1;
        lenSel[c] = 1'b1;
        rdata     = len_q[c];
      end
    end
  end

  // A running channel's ADDR/LEN are locked, so the engine sees stable parameters.
  assign blockErr = PWRITE & |((addrSel | lenSel) & busy_q);
  assign accessPh = PSEL & PENABLE;
  assign wrEn     = accessPh & PWRITE & mapped & ~blockErr;
  assign rdSetup  = PSEL & ~PENABLE & ~PWRITE;
  assign PSLVERR  = accessPh & (~mapped | blockErr);
  assign PREADY   = 1'b1;

  assign doneHit = done_i & busy_q;
  assign go_d    = ctrlSel & ~busy_q & {NUM_CH{wrEn & PWDATA[0]}};
  assign busy_d  = (busy_q | go_d) & ~doneHit;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      prdata_q <= '0;
      go_q     <= '0;
      busy_q   <= '0;
      addr_q   <= '0;
      len_q    <= '0;
    end else begin
      prdata_q <= rdSetup ? rdata : '0;
      go_q     <= go_d;
      busy_q   <= busy_d;
      for (int c = 0; c < NUM_CH; c++) begin
        if (wrEn & addrSel[c]) addr_q[c] <= PWDATA[31:0];
        if (wrEn & lenSel[c])  len_q[c]  <= PWDATA[31:0];
      end
    end
  end

  assign PRDATA = prdata_q;
  assign go_o   = go_q;
  assign addr_o = addr_q;
  assign len_o  = len_q;

`ifdef DPU_CSR_IRQ_EN
  // The clear is applied before the set, so a completion in the same cycle as a W1C wins.
  assign irqStat_d = (irqStat_q & ~({NUM_CH{wrEn & istSel}} & PWDATA[NUM_CH-1:0])) | doneHit;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      irqEn_q   <= '0;
      irqStat_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      if (wrEn & ienSel) irqEn_q <= PWDATA[NUM_CH-1:0];
      irqStat_q <= irqStat_d;
      irq_q     <= |(irqStat_q & irqEn_q);
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_dpu_csr_bank.sv
// Self-checking bench for dpu_csr_bank: directed register-map checks plus randomized APB/done traffic.
// A register-level model scores the outputs on every falling edge.

module tb_dpu_csr_bank;

  localparam int          NCH         = 4;
  localparam logic [31:0] VERSION_EXP = 32'h2021_1106;
  localparam logic [31:0] CONFIG_EXP  = 32'h0400_2020;

  logic             PCLK = 1'b0;
  logic             PRESET, PSEL, PENABLE, PWRITE, psel2;
  logic [31:0]      PADDR, PWDATA, PRDATA, PRDATA2;
  logic             PREADY, PSLVERR, PREADY2, PSLVERR2;
  logic [NCH-1:0]   go_o, done_i;
  logic [NCH*32-1:0] addr_o, len_o;
  logic             irq_o;
  logic [1:0]       go2, done2;
  logic [63:0]      addr2, len2;
  logic             irq2;

  int vectors     = 0;
  int miscompares = 0;
  bit checkEn     = 1'b0;
  bit randDone    = 1'b0;

  // Reference state, kept as plain per-channel arrays.
  logic [31:0] mAddr[NCH];
  logic [31:0] mLen[NCH];
  bit          mBusy[NCH];
  bit          mStat[NCH];
  bit          mIen[NCH];
  bit          mGo[NCH];
  logic [31:0] mPrdata;
  bit          mIrq;

  always #5 PCLK = ~PCLK;

  dpu_csr_bank #(.NUM_CH(NCH)) u_dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .go_o(go_o), .addr_o(addr_o), .len_o(len_o), .done_i(done_i), .irq_o(irq_o)
  );

  dpu_csr_bank #(.NUM_CH(2)) u_dut2 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel2), .PENABLE(PENABLE), .PADDR(PADDR),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA2), .PREADY(PREADY2), .PSLVERR(PSLVERR2),
    .go_o(go2), .addr_o(addr2), .len_o(len2), .done_i(done2), .irq_o(irq2)
  );

  assign done2 = 2'b00;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Kind codes: 0 unmapped, 1 VERSION, 2 CONFIG, 3 IRQ_EN, 4 IRQ_STAT, 5 CTRL, 6 ADDR, 7 LEN.
  function automatic int decode(input logic [7:0] a, output int ch);
    int ai;
    ai = int'(a);
    ch = 0;
    if (ai == 0) return 1;
    if (ai == 4) return 2;
`ifdef DPU_CSR_IRQ_EN
    if (ai == 8) return 3;
    if (ai == 12) return 4;
`endif
    if (ai >= 64 && ai < 64 + 16 * NCH) begin
      ch = (ai - 64) / 16;
      if (ai % 16 == 0) return 5;
      if (ai % 16 == 4) return 6;
      if (ai % 16 == 8) return 7;
    end
    return 0;
  endfunction

  function automatic logic [31:0] modelRead(input logic [7:0] a);
    int          ch, kind;
    logic [31:0] v;
    v    = '0;
    kind = decode(a, ch);
    case (kind)
      1: v = VERSION_EXP;
      2: v = CONFIG_EXP;
      3: for (int i = 0; i < NCH; i++) v[i] = mIen[i];
      4: for (int i = 0; i < NCH; i++) v[i] = mStat[i];
      5: v = mBusy[ch] ? 32'd2 : 32'd0;
      6: v = mAddr[ch];
      7: v = mLen[ch];
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic bit expErr();
    int ch, kind;
    kind = decode(PADDR[7:0], ch);
    if (kind == 0) return 1'b1;
    if (PWRITE && (kind == 6 || kind == 7) && mBusy[ch]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NCH; i++) begin
      mAddr[i] = '0; mLen[i] = '0; mBusy[i] = 0; mStat[i] = 0; mIen[i] = 0; mGo[i] = 0;
    end
    mPrdata = '0;
    mIrq    = 0;
  endtask

  task automatic modelStep();
    bit wasBusy[NCH];
    bit anyIrq;
    int kind, ch;
    anyIrq = 0;
    for (int i = 0; i < NCH; i++) begin
      wasBusy[i] = mBusy[i];
      anyIrq     = anyIrq | (mStat[i] & mIen[i]);
      mGo[i]     = 0;
    end
`ifdef DPU_CSR_IRQ_EN
    mIrq = anyIrq;
`else
    mIrq = 0;
`endif
    mPrdata = (PSEL && !PENABLE && !PWRITE) ? modelRead(PADDR[7:0]) : 32'd0;
    if (PSEL && PENABLE && PWRITE) begin
      kind = decode(PADDR[7:0], ch);
      case (kind)
        3: for (int i = 0; i < NCH; i++) mIen[i] = PWDATA[i];
        4: for (int i = 0; i < NCH; i++) if (PWDATA[i]) mStat[i] = 0;
        5: if (PWDATA[0] && !wasBusy[ch]) begin mGo[ch] = 1; mBusy[ch] = 1; end
        6: if (!wasBusy[ch]) mAddr[ch] = PWDATA;
        7: if (!wasBusy[ch]) mLen[ch] = PWDATA;
        default: ;
      endcase
    end
    for (int i = 0; i < NCH; i++) begin
      if (done_i[i] && wasBusy[i]) begin
        mBusy[i] = 0;
        mStat[i] = 1;
      end
    end
  endtask

  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) modelReset();
    else modelStep();
  end

  function automatic logic [NCH-1:0] packGo();
    logic [NCH-1:0] r;
    for (int i = 0; i < NCH; i++) r[i] = mGo[i];
    return r;
  endfunction

  function automatic logic [NCH*32-1:0] packRegs(input bit isLen);
    logic [NCH*32-1:0] r;
    for (int i = 0; i < NCH; i++) r[i*32 +: 32] = isLen ? mLen[i] : mAddr[i];
    return r;
  endfunction

  // Scoreboard: every output is compared with the model on each falling edge.
  always @(negedge PCLK) begin
    if (checkEn) begin
      checkOutput("go_o", 128'(go_o), 128'(packGo()));
      checkOutput("addr_o", 128'(addr_o), 128'(packRegs(1'b0)));
      checkOutput("len_o", 128'(len_o), 128'(packRegs(1'b1)));
      checkOutput("irq_o", 128'(irq_o), 128'(mIrq));
      checkOutput("PRDATA", 128'(PRDATA), 128'(mPrdata));
      checkOutput("PREADY", 128'(PREADY), 128'(1));
      if (PSEL && PENABLE) checkOutput("PSLVERR", 128'(PSLVERR), 128'(expErr()));
    end
  end

  task automatic tick();
    @(posedge PCLK);
    #2;
    if (randDone && $urandom_range(0, 3) == 0) done_i = NCH'($urandom);
    else done_i = '0;
  endtask

  task automatic apbWrite(input logic [31:0] a, input logic [31:0] d, input logic [NCH-1:0] doneMask,
                          output logic err);
    tick();
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    tick();
    PENABLE = 1'b1;
    done_i  = done_i | doneMask;
    @(negedge PCLK);
    err = PSLVERR;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apbRead(input logic [31:0] a, input bit second, output logic [31:0] data, output logic err);
    tick();
    if (second) psel2 = 1'b1;
    else PSEL = 1'b1;
    PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    tick();
    PENABLE = 1'b1;
    @(negedge PCLK);
    data = second ? PRDATA2 : PRDATA;
    err  = second ? PSLVERR2 : PSLVERR;
    tick();
    PSEL = 1'b0; psel2 = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic applyStimulus();
    logic [7:0]  a;
    logic [31:0] d, rd;
    logic        e;
    int          sel;
    sel = int'($urandom_range(0, 9));
    if (sel < 6) a = 8'(64 + 16 * $urandom_range(0, NCH) + 4 * $urandom_range(0, 3));
    else if (sel == 7) a = 8'($urandom);
    else a = 8'(4 * $urandom_range(0, 3));
    d = $urandom;
    if (a[3:0] == 4'h0 && $urandom_range(0, 1) == 1) d[0] = 1'b1;
    if ($urandom_range(0, 1) == 1) apbWrite({24'($urandom), a}, d, '0, e);
    else apbRead({24'($urandom), a}, 1'b0, rd, e);
    repeat ($urandom_range(0, 2)) tick();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    int          cnt;
    PRESET = 1'b1; PSEL = 1'b0; psel2 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; done_i = '0;
    repeat (3) @(negedge PCLK);
    checkOutput("reset go_o", 128'(go_o), 128'(0));
    checkOutput("reset PRDATA", 128'(PRDATA), 128'(0));
    checkOutput("reset irq_o", 128'(irq_o), 128'(0));
    checkOutput("reset addr_o", 128'(addr_o), 128'(0));
    checkEn = 1'b1;
    @(posedge PCLK); #2;
    PRESET = 1'b0;

    apbRead(32'h0, 1'b0, d, e);
    checkOutput("VERSION", 128'(d), 128'(32'h2021_1106));
    checkOutput("VERSION err", 128'(e), 128'(0));
    apbRead(32'h4, 1'b0, d, e);
    checkOutput("CONFIG", 128'(d), 128'(32'h0400_2020));
    checkOutput("CONFIG err", 128'(e), 128'(0));
    apbRead(32'hABCD_EF00, 1'b0, d, e);
    checkOutput("VERSION high addr", 128'(d), 128'(32'h2021_1106));

    apbWrite(32'h44, 32'h1000_0000, '0, e);
    checkOutput("ADDR0 write err", 128'(e), 128'(0));
    apbWrite(32'h48, 32'h100, '0, e);
    checkOutput("addr_o ch0", 128'(addr_o[31:0]), 128'(32'h1000_0000));
    checkOutput("len_o ch0", 128'(len_o[31:0]), 128'(32'h100));

    apbWrite(32'h40, 32'h1, '0, e);
    cnt = 0;
    repeat (4) begin @(negedge PCLK); cnt += int'(go_o[0]); end
    checkOutput("go0 pulse count", 128'(cnt), 128'(1));
    apbRead(32'h40, 1'b0, d, e);
    checkOutput("CTRL0 busy", 128'(d), 128'(2));
    apbWrite(32'h40, 32'h1, '0, e);
    cnt = 0;
    repeat (4) begin @(negedge PCLK); cnt += int'(go_o[0]); end
    checkOutput("go0 while busy", 128'(cnt), 128'(0));

    apbWrite(32'h44, 32'h0000_DEAD, '0, e);
    checkOutput("ADDR0 busy err", 128'(e), 128'(1));
    apbRead(32'h44, 1'b0, d, e);
    checkOutput("ADDR0 kept", 128'(d), 128'(32'h1000_0000));

`ifdef DPU_CSR_IRQ_EN
    apbWrite(32'h08, 32'h1, '0, e);
`endif
    tick(); done_i = 4'b0001; tick();
    apbRead(32'h40, 1'b0, d, e);
    checkOutput("CTRL0 idle", 128'(d), 128'(0));
`ifdef DPU_CSR_IRQ_EN
    apbRead(32'h0C, 1'b0, d, e);
    checkOutput("IRQ_STAT after done", 128'(d), 128'(1));
    checkOutput("irq_o after done", 128'(irq_o), 128'(1));
    apbWrite(32'h40, 32'h1, '0, e);
    apbWrite(32'h0C, 32'h1, 4'b0001, e);
    apbRead(32'h0C, 1'b0, d, e);
    checkOutput("IRQ_STAT set wins", 128'(d), 128'(1));
    checkOutput("irq_o held", 128'(irq_o), 128'(1));
`else
    apbRead(32'h08, 1'b0, d, e);
    checkOutput("IRQ_EN unmapped err", 128'(e), 128'(1));
    checkOutput("IRQ_EN unmapped data", 128'(d), 128'(0));
`endif

    apbRead(32'h80, 1'b0, d, e);
    checkOutput("ch4 unmapped err", 128'(e), 128'(1));
    checkOutput("ch4 unmapped data", 128'(d), 128'(0));
    apbWrite(32'h4C, 32'hFFFF_FFFF, '0, e);
    checkOutput("0x4C err", 128'(e), 128'(1));
    apbRead(32'h70, 1'b0, d, e);
    checkOutput("CTRL3 mapped", 128'(e), 128'(0));
    apbRead(32'h70, 1'b1, d, e);
    checkOutput("2ch 0x70 err", 128'(e), 128'(1));
    checkOutput("2ch 0x70 data", 128'(d), 128'(0));
    apbRead(32'h50, 1'b1, d, e);
    checkOutput("2ch CTRL1 err", 128'(e), 128'(0));

    apbWrite(32'h50, 32'h1, '0, e);
    @(negedge PCLK);
    checkOutput("go1 pulse", 128'(go_o[1]), 128'(1));
    #1 PRESET = 1'b1;
    #1;
    checkOutput("async go_o", 128'(go_o), 128'(0));
    checkOutput("async irq_o", 128'(irq_o), 128'(0));
    checkOutput("async PRDATA", 128'(PRDATA), 128'(0));
    tick(); tick();
    PRESET = 1'b0;
    tick(); done_i = 4'b0010; tick();
    apbRead(32'h50, 1'b0, d, e);
    checkOutput("CTRL1 after reset", 128'(d), 128'(0));
    apbRead(32'h44, 1'b0, d, e);
    checkOutput("ADDR0 after reset", 128'(d), 128'(0));
`ifdef DPU_CSR_IRQ_EN
    apbRead(32'h0C, 1'b0, d, e);
    checkOutput("IRQ_STAT stale done", 128'(d), 128'(0));
`endif

    randDone = 1'b1;
    repeat (400) applyStimulus();
    randDone = 1'b0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
